tone_generator: RTL and testbench
=================================

// Module: tone_generator
// PURPOSE
//   Consumer end of the song-player note interface (note / duration / play_enable).
//   Converts each note request into a square wave on the buzzer pin.
//   Times each note locally and reports completion.
//   Sits between the song player and the board buzzer; runs on the 12 MHz system clock.
// PARAMETERS
//   GAP_CYCLES  120000  silent articulation tail per note, in clk cycles (10 ms); used only with ARTIC_GAP_EN
// PORTS
//   clk          in   1   system clock, 12 MHz
//   rst          in   1   synchronous, active-high reset
//   note         in   8   note code: 0=REST, 1..7=L1..L7, 8..14=M1..M7, 15=H1, 16=H2
//   duration     in   24  note length in clk cycles
//   play_enable  in   1   request level from the player; its rising edge starts a note
//   beep         out  1   square-wave buzzer drive
//   tone_on      out  1   1 while an audible note is sounding
//   note_done    out  1   1-cycle pulse when a note completes normally
//   busy         out  1   1 in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE; beep=0, tone_on=0, note_done=0, busy=0; all counters=0; play_enable history reg=0.
//   Edge detect: start = play_enable & ~pe_d, where pe_d is play_enable registered by one cycle.
//   Half-period table (HP = round(6e6/f)), 16-bit:
//     1:22934  2:20432  3:18202  4:17181  5:15306  6:13636  7:12149  8:11467
//     9:10216 10:9101  11:8590  12:7653  13:6818  14:6074  15:5733  16:5108
//     0 or >16: silent (HP unused).
//   FSM IDLE / TONE / GAP:
//     IDLE: on start, capture note and HP, load dur_cnt=duration, clear half_cnt, beep=0.
//       - duration==0: stay IDLE and pulse note_done on the next cycle.
//       - otherwise: go to TONE.
//     TONE: dur_cnt decrements once per cycle.
//       - half_cnt counts 0..HP-1; at HP-1, toggle beep and wrap to 0.
//       - First toggle occurs HP cycles after TONE entry.
//       - Silent note: beep and tone_on held at 0; timing is unchanged.
//       - Terminal: dur_cnt==1 (note lasts exactly duration cycles in TONE).
//         Go to GAP if the macro is enabled, else to IDLE with note_done=1 for 1 cycle.
//     GAP: beep=0, tone_on=0 (see CONFIGURATION).
//   tone_on = (state==TONE) & audible note.
//   Abort: play_enable==0 in TONE or GAP -> next cycle IDLE, beep=0, no note_done.
//   Terminal count and play_enable falling in the same cycle: completion wins and note_done pulses.
//   A note input change during TONE is ignored; values are captured only at start.
//   Reset asserted mid-note: outputs return to reset values on the next edge; no note_done.
//   Width: dur_cnt 24-bit; no overflow is possible because it is only decremented.
// CONFIGURATION
//   ARTIC_GAP_EN defined:
//     - The last min(GAP_CYCLES, duration-1) cycles of each note are silent; TONE is shortened accordingly.
//     - Total note time is still exactly duration cycles.
//     - note_done pulses when the gap ends.
//     - Result: repeated identical notes are audibly separated.
//   ARTIC_GAP_EN undefined:
//     - No GAP state; the tone lasts the full duration.
//     - GAP_CYCLES is ignored.
// TESTING (bench overrides GAP_CYCLES=10)
//   1. note=8 (M1), duration=100000, play_enable rises -> beep first toggles 11467 cycles after TONE entry;
//      period 22934; note_done pulses once, 100000 cycles after start; busy falls with it.
//   2. note=0, duration=500 -> beep=0 and tone_on=0 throughout; note_done after 500 cycles.
//   3. note=16, duration=30000, play_enable drops at cycle 12000 -> beep=0 and IDLE next cycle; no note_done.
//   4. duration=0 request -> busy stays 0; note_done pulses one cycle after start.
//   5. ARTIC_GAP_EN defined, note=15, duration=20000 -> beep toggles through cycle 19990, then silent 10 cycles;
//      note_done at cycle 20000.
//   6. rst=1 at cycle 5000 of a note=12 tone -> beep=0, tone_on=0, busy=0 next cycle;
//      a fresh rising edge of play_enable restarts cleanly.

Source files
------------

// File: rtl/tone_generator.sv
// Square-wave tone generator driven by the song player's note/duration/play_enable handshake.
// Optional ARTIC_GAP_EN adds a silent articulation tail at the end of each note.
module tone_generator #(
  parameter int unsigned GAP_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  note,
  input  logic [23:0] duration,
  input  logic        play_enable,
  output logic        beep,
  output logic        tone_on,
  output logic        note_done,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StTone, StGap} state_e;

  state_e      state_q, state_d;
  logic        pe_q;
  logic        start;
  logic [23:0] dur_cnt_q, dur_cnt_d;
  logic [15:0] half_cnt_q, half_cnt_d;
  logic [15:0] hp_q, hp_d, hp_lut;
  logic        audible_q, audible_d;
  logic        beep_q, beep_d;
  logic        done_q, done_d;
  logic        tone_end;
`ifdef ARTIC_GAP_EN
  logic [23:0] gap_q, gap_d;
`endif

  assign start = play_enable & ~pe_q;

  always_comb begin
    hp_lut = 16'd0;
    case (note)
      8'd1:    hp_lut = 16'd22934;
      8'd2:    hp_lut = 16'd20432;
      8'd3:    hp_lut = 16'd18202;
      8'd4:    hp_lut = 16'd17181;
      8'd5:    hp_lut = 16'd15306;
      8'd6:    hp_lut = 16'd13636;
      8'd7:    hp_lut = 16'd12149;
      8'd8:    hp_lut = 16'd11467;
      8'd9:    hp_lut = 16'd10216;
      8'd10:   hp_lut = 16'd9101;
      8'd11:   hp_lut = 16'd8590;
      8'd12:   hp_lut = 16'd7653;
      8'd13:   hp_lut = 16'd6818;
      8'd14:   hp_lut = 16'd6074;
      8'd15:   hp_lut = 16'd5733;
      8'd16:   hp_lut = 16'd5108;
      default: hp_lut = 16'd0;
    endcase
  end

  // With the gap enabled, TONE hands over once only the gap's worth of cycles remain.
`ifdef ARTIC_GAP_EN
  assign tone_end = (dur_cnt_q == gap_q + 24'd1);
`else
  assign tone_end = (dur_cnt_q == 24'd1);
`endif

  always_comb begin
    state_d    = state_q;
    dur_cnt_d  = dur_cnt_q;
    half_cnt_d = half_cnt_q;
    hp_d       = hp_q;
    audible_d  = audible_q;
    beep_d     = beep_q;
    done_d     = 1'b0;
`ifdef ARTIC_GAP_EN
    gap_d      = gap_q;
`endif
    case (state_q)
      StIdle: begin
        beep_d = 1'b0;
        if (start) begin
          hp_d       = hp_lut;
          audible_d  = (note != 8'd0) && (note <= 8'd16);
          dur_cnt_d  = duration;
          half_cnt_d = 16'd0;
`ifdef ARTIC_GAP_EN
          if (GAP_CYCLES < {8'd0, duration}) gap_d = GAP_CYCLES[23:0];
          else                               gap_d = duration - 24'd1;
`endif
          if (duration == 24'd0) done_d = 1'b1;
          else                   state_d = StTone;
        end
      end
      StTone: begin
        dur_cnt_d = dur_cnt_q - 24'd1;
        if (half_cnt_q == hp_q - 16'd1) begin
          half_cnt_d = 16'd0;
          beep_d     = audible_q & ~beep_q;
        end else begin
          half_cnt_d = half_cnt_q + 16'd1;
        end
        // Completion takes priority over a simultaneous play_enable drop.
        if (tone_end) begin
          beep_d = 1'b0;
`ifdef ARTIC_GAP_EN
          if (gap_q != 24'd0) begin
            state_d = StGap;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
`else
          state_d = StIdle;
          done_d  = 1'b1;
`endif
        end else if (!play_enable) begin
          state_d = StIdle;
          beep_d  = 1'b0;
        end
      end
`ifdef ARTIC_GAP_EN
      StGap: begin
        dur_cnt_d = dur_cnt_q - 24'd1;
        beep_d    = 1'b0;
        if (dur_cnt_q == 24'd1) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (!play_enable) begin
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        beep_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pe_q       <= 1'b0;
      dur_cnt_q  <= 24'd0;
      half_cnt_q <= 16'd0;
      hp_q       <= 16'd0;
      audible_q  <= 1'b0;
      beep_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ARTIC_GAP_EN
      gap_q      <= 24'd0;
`endif
    end else begin
      state_q    <= state_d;
      pe_q       <= play_enable;
      dur_cnt_q  <= dur_cnt_d;
      half_cnt_q <= half_cnt_d;
      hp_q       <= hp_d;
      audible_q  <= audible_d;
      beep_q     <= beep_d;
      done_q     <= done_d;
`ifdef ARTIC_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign beep      = beep_q;
  assign note_done = done_q;
  assign busy      = (state_q != StIdle);
  assign tone_on   = (state_q == StTone) && audible_q;

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: expected beep edges, note_done pulses and status
// snapshots are queued by the stimulus and checked by an independent negedge monitor.
module tb_tone_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  note = 8'd0;
  logic [23:0] duration = 24'd0;
  logic        play_enable = 1'b0;
  logic        beep, tone_on, note_done, busy;

  tone_generator #(.GAP_CYCLES(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .note        (note),
    .duration    (duration),
    .play_enable (play_enable),
    .beep        (beep),
    .tone_on     (tone_on),
    .note_done   (note_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0 = beep edge (val = new level), kind 1 = note_done pulse
  typedef struct {
    string name;
    int    kind;
    int    cyc;
    logic  val;
  } ev_t;

  typedef struct {
    string      name;
    logic [2:0] exp;  // {tone_on, busy, beep}
  } st_t;

  ev_t  ev_q[$];
  st_t  st_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  task automatic exp_ev(input string name, input int kind, input int c, input logic val);
    ev_t e;
    e.name = name; e.kind = kind; e.cyc = c; e.val = val;
    ev_q.push_back(e);
  endtask

  task automatic exp_st(input string name, input logic [2:0] exp);
    st_t s;
    s.name = name; s.exp = exp;
    st_q.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_note(input logic [7:0] n, input logic [23:0] d, output int t0);
    note = n;
    duration = d;
    play_enable = 1'b1;
    t0 = cyc + 1;
  endtask

  // Monitor
  initial begin
    logic beep_prev;
    beep_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (beep !== beep_prev) begin
        check_event(0, beep);
        beep_prev = beep;
      end
      if (note_done === 1'b1) check_event(1, 1'b1);
      while (st_q.size() > 0) begin
        st_t s;
        s = st_q.pop_front();
        n_checks++;
        if ({tone_on, busy, beep} !== s.exp) begin
          n_errors++;
          $display("FAIL %s: got tone_on,busy,beep=%b required %b at cycle %0d",
                   s.name, {tone_on, busy, beep}, s.exp, cyc);
        end
      end
      if (end_req && !end_done) begin
        end_done = 1'b1;
        while (ev_q.size() > 0) begin
          ev_t e;
          e = ev_q.pop_front();
          n_checks++;
          n_errors++;
          $display("FAIL %s: got no event required kind=%0d val=%0b at cycle %0d",
                   e.name, e.kind, e.val, e.cyc);
        end
      end
    end
  end

  task automatic check_event(input int kind, input logic val);
    ev_t e;
    n_checks++;
    if (ev_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected: got kind=%0d val=%0b at cycle %0d required no event",
               kind, val, cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: got kind=%0d val=%0b cyc=%0d required kind=%0d val=%0b cyc=%0d",
                 e.name, kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Stimulus
  initial begin
    int t0;
    tick(3);
    rst = 1'b0;
    exp_st("reset_state", 3'b000);
    tick(2);

    // M1: HP 11467; note input change mid-tone must be ignored
    start_note(8'd8, 24'd25000, t0);
    exp_ev("m1_rise", 0, t0 + 11467, 1'b1);
    exp_ev("m1_fall", 0, t0 + 22934, 1'b0);
    exp_ev("m1_done", 1, t0 + 25000, 1'b1);
    tick(1);
    tick(5000);
    exp_st("m1_mid", 3'b110);
    note = 8'd16;
    tick(7000);
    exp_st("m1_high", 3'b111);
    tick(13000);
    exp_st("m1_after", 3'b000);
    play_enable = 1'b0;
    tick(2);

    // Rest note: silent but timed
    start_note(8'd0, 24'd500, t0);
    exp_ev("rest_done", 1, t0 + 500, 1'b1);
    tick(1);
    tick(100);
    exp_st("rest_mid", 3'b010);
    tick(400);
    exp_st("rest_after", 3'b000);
    play_enable = 1'b0;
    tick(2);

    // H2 aborted by play_enable falling: no note_done
    start_note(8'd16, 24'd30000, t0);
    exp_ev("h2_rise", 0, t0 + 5108, 1'b1);
    exp_ev("h2_fall", 0, t0 + 10216, 1'b0);
    tick(1);
    tick(6000);
    exp_st("h2_high", 3'b111);
    tick(5999);
    exp_st("h2_pre_abort", 3'b110);
    play_enable = 1'b0;
    tick(1);
    exp_st("h2_abort", 3'b000);
    tick(2);

    // Zero duration: immediate done, never busy
    start_note(8'd5, 24'd0, t0);
    exp_ev("zero_done", 1, t0, 1'b1);
    tick(1);
    exp_st("zero_busy", 3'b000);
    play_enable = 1'b0;
    tick(3);

    // H1: articulation gap silences the last 10 cycles when enabled
    start_note(8'd15, 24'd8000, t0);
    exp_ev("h1_rise", 0, t0 + 5733, 1'b1);
`ifdef ARTIC_GAP_EN
    exp_ev("h1_gap", 0, t0 + 7990, 1'b0);
    exp_ev("h1_done", 1, t0 + 8000, 1'b1);
    tick(1);
    tick(7995);
    exp_st("h1_in_gap", 3'b010);
    tick(5);
`else
    exp_ev("h1_end", 0, t0 + 8000, 1'b0);
    exp_ev("h1_done", 1, t0 + 8000, 1'b1);
    tick(1);
    tick(7995);
    exp_st("h1_late", 3'b111);
    tick(5);
`endif
    exp_st("h1_after", 3'b000);
    play_enable = 1'b0;
    tick(2);

    // Reset mid-note, then a clean restart
    start_note(8'd12, 24'd30000, t0);
    tick(1);
    tick(5000);
    exp_st("rst_pre", 3'b110);
    rst = 1'b1;
    play_enable = 1'b0;
    tick(1);
    exp_st("rst_applied", 3'b000);
    rst = 1'b0;
    tick(2);
    start_note(8'd1, 24'd300, t0);
    exp_ev("restart_done", 1, t0 + 300, 1'b1);
    tick(1);
    tick(150);
    exp_st("restart_mid", 3'b110);
    tick(150);
    exp_st("restart_after", 3'b000);
    play_enable = 1'b0;
    tick(5);

    end_req = 1'b1;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
